dtc_pe_sched: RTL and testbench
===============================

# dtc_pe_sched

Job scheduler for the 8-lane FP32 dot-product PE. It accepts dot-product jobs of one or more 8-element chunks and generates operand-buffer read addresses, one chunk per cycle. It tracks each chunk through the fixed-latency PE pipeline, which has no valid or stall. Each PE partial sum is captured into an internal output FIFO and emitted as a tagged stream with first/last markers for the downstream accumulator. Issue is credit-throttled so that backpressure can never drop a result.

## Interface
- `N_MUL`, 8, multiplier lanes per PE (one chunk = N_MUL elements)
- `DW_ADD`, 32, PE result width
- `PE_LAT`, 12, cycles from operands at PE input to valid PE `out`
- `ADDR_W`, 10, operand-buffer chunk address width
- `LEN_W`, 10, job length field width
- `TAG_W`, 4, job tag width
- `FIFO_DEPTH`, 16, output FIFO entries; power of two, must be ≥ PE_LAT+2
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `job_valid`  in  1  job request
- `job_ready`  out  1  job accepted when valid&ready
- `job_base_a`  in  ADDR_W  first chunk address, operand A buffer
- `job_base_b`  in  ADDR_W  first chunk address, operand B buffer
- `job_len_m1`  in  LEN_W  number of chunks minus one
- `job_tag`  in  TAG_W  job identifier
- `rd_en`  out  1  operand read strobe, both buffers (1-cycle read latency)
- `rd_addr_a`  out  ADDR_W  A chunk address
- `rd_addr_b`  out  ADDR_W  B chunk address
- `pe_out`  in  DW_ADD  PE result
- `ps_valid`  out  1  partial sum available
- `ps_ready`  in  1  downstream accept
- `ps_data`  out  DW_ADD  partial sum
- `ps_first`  out  1  first chunk of job
- `ps_last`  out  1  last chunk of job
- `ps_tag`  out  TAG_W  job tag
- `busy`  out  1  job issuing, chunk in flight, or FIFO non-empty

## Operation
- FSM states: IDLE, ISSUE.
  - IDLE: `job_ready`=1. On accept, latch bases, length and tag; clear the chunk counter; go to ISSUE.
  - ISSUE: `job_ready`=0. Issue one chunk per cycle while credit > 0.
    - Issued chunk i: `rd_addr_a`=base_a+i, `rd_addr_b`=base_b+i. Address addition wraps modulo 2^ADDR_W.
    - The cycle that issues i == len_m1 returns the FSM to IDLE.
- Credit = FIFO_DEPTH − fifo_count − inflight.
  - inflight counts issued chunks not yet written to the FIFO; width is clog2(FIFO_DEPTH)+1.
  - When credit is 0, `rd_en` is held low and the address does not advance. No chunk is ever lost.
- A delay line of depth 1+PE_LAT carries {valid, first, last, tag} from `rd_en`. When its output is valid, {pe_out, first, last, tag} is pushed into the FIFO.
- A FIFO push and a pop in the same cycle leave the count unchanged. A push with credit correctly accounted never finds the FIFO full; an overflow is an assertion failure.
- Jobs may overlap in flight. A new job is accepted the cycle after the previous job's last issue, and chunks of consecutive jobs are distinguished only by tag.
- `job_len_m1`=0 produces a single result with `ps_first`=`ps_last`=1.

## Timing
- Reset values (async assert, sync deassert assumed upstream):
  - `job_ready`=0 during reset, 1 from the first clock after release.
  - `rd_en`=0, addresses=0, `ps_valid`=0, `busy`=0.
  - FSM = IDLE; FIFO, delay line and counters cleared.
- Reset mid-job discards all in-flight and buffered results. No partial stream is emitted after reset.
- Job accept at cycle t gives the first `rd_en` at t+1.
- `rd_en` at cycle c gives a FIFO write at c+1+PE_LAT.
- With the FIFO empty and `ps_ready`=1, `ps_valid` rises at c+2+PE_LAT (registered FIFO output).
- Steady-state throughput is 1 chunk/cycle when `ps_ready`=1.
- `ps_*` follow valid/ready: while `ps_valid`=1 and `ps_ready`=0, all `ps_*` are held stable.
- `busy` is registered and deasserts the cycle after the last FIFO pop with nothing in flight and FSM=IDLE.

## Structure
- Shared package/header `dtc_pkg`:
  - FSM state encoding (IDLE=0, ISSUE=1);
  - default PE_LAT, DW_ADD, N_MUL;
  - a clog2 function.
- One sub-module: `dtc_sfifo`, a synchronous FIFO with parameters width and depth and ports push, pop, full, empty, count.
- The delay line, credit logic and FSM are inline.

## Test plan
- Reset, then job base_a=0x010, base_b=0x200, len_m1=3, tag=5 with `ps_ready`=1:
  - `rd_en` pulses 4 cycles, addresses 0x010–0x013 / 0x200–0x203;
  - 4 results with tag 5, first on #0, last on #3;
  - first `ps_valid` at accept+PE_LAT+3.
- `ps_ready`=0 held for 40 cycles with a len_m1=31 job:
  - issue stalls after exactly FIFO_DEPTH outstanding chunks;
  - release yields all 32 results in order, none dropped or duplicated.
- Back-to-back jobs tag 1 len_m1=0 and tag 2 len_m1=2:
  - second accepted 1 cycle after the first issue;
  - output sequence tags 1,2,2,2 with correct first/last flags.
- base_a=0x3FE, len_m1=3, ADDR_W=10: `rd_addr_a` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Assert `rst_n` low mid-job with 6 chunks in flight:
  - all outputs go to reset values immediately;
  - no `ps_valid` appears after release until a new job is issued.
- Random valid/ready, 1000 jobs vs. scoreboard: results match issue order per tag; FIFO-overflow assertion never fires.

Source files
------------

// File: rtl/dtc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_pkg
//  Purpose  : Shared constants for the dot-product PE job scheduler: FSM
//             state encoding, default PE geometry and a clog2 helper.
//  Revision : 1.0 - initial release
// ============================================================================
package dtc_pkg;

    // Scheduler FSM encoding
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ISSUE = 1'b1;

    // Default PE geometry
    localparam int c_PE_LAT = 12;
    localparam int c_DW_ADD = 32;
    localparam int c_N_MUL  = 8;

    // Ceiling log2, usable in constant expressions
    function automatic int dtc_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dtc_sfifo.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_sfifo
//  Purpose  : Synchronous FIFO with power-of-two depth, combinational head
//             read from a registered read pointer, and an occupancy count.
//  Revision : 1.0 - initial release
// ============================================================================
module dtc_sfifo
    import dtc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [dtc_clog2(DEPTH):0]  count
);

    localparam int c_AW = dtc_clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Depth is a power of two, so the count MSB alone marks a full FIFO
    assign full  = r_count[c_CW-1];
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; simultaneous push and pop hold the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            assert (!(push && full));
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtc_pe_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dtc_pe_sched
//  Purpose  : Job scheduler for the 8-lane FP32 dot-product PE. Issues one
//             operand chunk per cycle, tracks chunks through the fixed-latency
//             PE, and streams tagged partial sums from an output FIFO. Issue is
//             credit-limited so downstream backpressure never drops a result.
//  Revision : 1.0 - initial release
// ============================================================================
module dtc_pe_sched
    import dtc_pkg::*;
#(
    parameter int N_MUL      = c_N_MUL,
    parameter int DW_ADD     = c_DW_ADD,
    parameter int PE_LAT     = c_PE_LAT,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_base_a,
    input  logic [ADDR_W-1:0] job_base_b,
    input  logic [LEN_W-1:0]  job_len_m1,
    input  logic [TAG_W-1:0]  job_tag,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DW_ADD-1:0] pe_out,
    output logic              ps_valid,
    input  logic              ps_ready,
    output logic [DW_ADD-1:0] ps_data,
    output logic              ps_first,
    output logic              ps_last,
    output logic [TAG_W-1:0]  ps_tag,
    output logic              busy
);

    localparam int c_CW       = dtc_clog2(FIFO_DEPTH) + 1;
    localparam int c_DL_DEPTH = 1 + PE_LAT;
    localparam int c_META_W   = 2 + TAG_W;
    localparam int c_ENTRY_W  = DW_ADD + c_META_W;
    localparam logic [c_CW:0] c_CREDIT_MAX = FIFO_DEPTH[c_CW:0];

    // Reject parameter sets the credit scheme cannot sustain
    if (N_MUL < 1 || FIFO_DEPTH < PE_LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("dtc_pe_sched: illegal parameter set");
    end

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                r_live;
    logic [ADDR_W-1:0]   r_base_a;
    logic [ADDR_W-1:0]   r_base_b;
    logic [LEN_W-1:0]    r_len_m1;
    logic [LEN_W-1:0]    r_cnt;
    logic [TAG_W-1:0]    r_tag;
    logic [c_CW-1:0]     r_inflight;
    logic [c_CW-1:0]     w_inflight_nxt;
    logic [c_DL_DEPTH-1:0] r_dl_vld;
    logic [c_META_W-1:0] r_dl_meta [c_DL_DEPTH];
    logic                r_busy;
    logic                w_busy_nxt;
    logic                w_accept;
    logic                w_last_issue;
    logic                w_has_credit;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_CW-1:0]     w_fifo_count;
    logic [c_CW-1:0]     w_count_nxt;
    logic [c_CW:0]       w_used;
    logic [c_ENTRY_W-1:0] w_fifo_dout;

    assign w_accept     = job_valid && job_ready;
    assign w_last_issue = rd_en && (r_cnt == r_len_m1);
    assign w_used       = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign w_has_credit = (w_used < c_CREDIT_MAX);
    assign w_push       = r_dl_vld[c_DL_DEPTH-1];
    assign w_pop        = ps_valid && ps_ready;

    assign rd_addr_a = r_base_a + ADDR_W'(r_cnt);
    assign rd_addr_b = r_base_b + ADDR_W'(r_cnt);

    // FSM state register; r_live holds job_ready low until the first clock after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    // FSM next state: leave IDLE on accept, return after the final chunk issues
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept)     w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: if (w_last_issue) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM outputs: accept jobs in IDLE, issue chunks in ISSUE while credit remains
    always_comb begin
        job_ready = 1'b0;
        rd_en     = 1'b0;
        case (r_state)
            c_ST_IDLE:  job_ready = r_live;
            c_ST_ISSUE: rd_en     = w_has_credit;
            default:    ;
        endcase
    end

    // Job descriptor latch and chunk counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_a <= '0;
            r_base_b <= '0;
            r_len_m1 <= '0;
            r_tag    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_base_a <= job_base_a;
            r_base_b <= job_base_b;
            r_len_m1 <= job_len_m1;
            r_tag    <= job_tag;
            r_cnt    <= '0;
        end else if (rd_en) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Delay line matching read latency plus PE latency, carrying chunk identity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DL_DEPTH; i++) begin
                r_dl_vld[i]  <= 1'b0;
                r_dl_meta[i] <= '0;
            end
        end else begin
            r_dl_vld[0]  <= rd_en;
            r_dl_meta[0] <= {(r_cnt == '0), (r_cnt == r_len_m1), r_tag};
            for (int i = 1; i < c_DL_DEPTH; i++) begin
                r_dl_vld[i]  <= r_dl_vld[i-1];
                r_dl_meta[i] <= r_dl_meta[i-1];
            end
        end
    end

    assign w_inflight_nxt = r_inflight + {{(c_CW-1){1'b0}}, rd_en} - {{(c_CW-1){1'b0}}, w_push};
    assign w_count_nxt    = w_fifo_count + {{(c_CW-1){1'b0}}, w_push} - {{(c_CW-1){1'b0}}, w_pop};
    assign w_busy_nxt     = (w_state_nxt == c_ST_ISSUE) || (w_inflight_nxt != '0) || (w_count_nxt != '0);

    // In-flight chunk count and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

    dtc_sfifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ofifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   ({pe_out, r_dl_meta[c_DL_DEPTH-1]}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign ps_valid = !w_fifo_empty;
    assign ps_data  = w_fifo_dout[c_ENTRY_W-1 -: DW_ADD];
    assign ps_first = w_fifo_dout[TAG_W+1];
    assign ps_last  = w_fifo_dout[TAG_W];
    assign ps_tag   = w_fifo_dout[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_dtc_pe_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtc_pe_sched
//  Purpose  : Self-checking bench for dtc_pe_sched. A transaction-level model
//             (job queue, outstanding-chunk credit, time-stamped result queue)
//             predicts every output each cycle; directed scenarios add literal
//             expectations on addresses, tags, flags and latencies.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dtc_pe_sched;

    localparam int PE_LAT     = 12;
    localparam int FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [9:0]  job_base_a = '0;
    logic [9:0]  job_base_b = '0;
    logic [9:0]  job_len_m1 = '0;
    logic [3:0]  job_tag = '0;
    logic        rd_en;
    logic [9:0]  rd_addr_a;
    logic [9:0]  rd_addr_b;
    logic [31:0] pe_out = '0;
    logic        ps_valid;
    logic        ps_ready = 1'b0;
    logic [31:0] ps_data;
    logic        ps_first;
    logic        ps_last;
    logic [3:0]  ps_tag;
    logic        busy;

    always #5 clk = ~clk;

    dtc_pe_sched #(
        .N_MUL(8), .DW_ADD(32), .PE_LAT(PE_LAT), .ADDR_W(10),
        .LEN_W(10), .TAG_W(4), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_base_a(job_base_a), .job_base_b(job_base_b),
        .job_len_m1(job_len_m1), .job_tag(job_tag),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .pe_out(pe_out),
        .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data),
        .ps_first(ps_first), .ps_last(ps_last), .ps_tag(ps_tag),
        .busy(busy)
    );

    typedef struct {
        int          issue;
        int          avail;
        logic [31:0] data;
        bit          first;
        bit          last;
        logic [3:0]  tag;
    } ent_t;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] len;
        logic [3:0] tag;
    } job_t;

    // Reference model state
    ent_t        mq[$];
    job_t        req_q[$];
    bit          m_live, m_pend;
    logic [9:0]  m_ba, m_bb, m_len, m_idx;
    logic [3:0]  m_tag;
    int          m_issued, m_popped;
    bit          e_ready, e_rd, e_psv, e_busy;
    logic [9:0]  e_a, e_b;

    int          cyc = 0;
    bit          chk_en = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rnd_ready = 0, rnd_job = 0, fix_ready = 1;

    // Observation logs for the directed literal checks
    logic [9:0]  log_a[$];
    logic [9:0]  log_b[$];
    int          log_rdc[$];
    logic [5:0]  log_out[$];
    int          log_acc[$];
    int          first_psv = -1;
    int          n_psv_seen = 0;
    int          total_pops = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_pend = 0;
        m_ba = '0; m_bb = '0; m_len = '0; m_idx = '0; m_tag = '0;
        m_issued = 0; m_popped = 0;
        mq.delete();
    endtask

    task automatic compute_exp();
        e_ready = m_live && !m_pend;
        e_rd    = m_pend && ((m_issued - m_popped) < FIFO_DEPTH);
        e_a     = m_ba + m_idx;
        e_b     = m_bb + m_idx;
        e_psv   = (mq.size() > 0) && (mq[0].avail <= cyc);
        e_busy  = m_pend || (m_issued != m_popped);
    endtask

    // Advance the model across the clock edge that ended cycle cyc-1
    task automatic model_update();
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        foreach (mq[i]) begin
            if (mq[i].issue + PE_LAT + 1 == cyc - 1) mq[i].data = pe_out;
        end
        if (e_psv && ps_ready) begin
            void'(mq.pop_front());
            m_popped++;
        end
        if (e_rd) begin
            e.issue = cyc - 1;
            e.avail = cyc - 1 + PE_LAT + 2;
            e.data  = '0;
            e.first = (m_idx == 10'd0);
            e.last  = (m_idx == m_len);
            e.tag   = m_tag;
            mq.push_back(e);
            m_issued++;
            if (m_idx == m_len) m_pend = 0;
            m_idx = m_idx + 10'd1;
        end
        if (e_ready && job_valid) begin
            m_pend = 1;
            m_ba = job_base_a; m_bb = job_base_b;
            m_len = job_len_m1; m_tag = job_tag; m_idx = '0;
            void'(req_q.pop_front());
        end
        m_live = 1;
    endtask

    task automatic drive();
        pe_out   = $urandom;
        ps_ready = rnd_ready ? ($urandom_range(0, 99) < 70) : fix_ready;
        if (req_q.size() > 0 && (job_valid || !rnd_job || $urandom_range(0, 2) == 0)) begin
            job_valid  = 1'b1;
            job_base_a = req_q[0].a;
            job_base_b = req_q[0].b;
            job_len_m1 = req_q[0].len;
            job_tag    = req_q[0].tag;
        end else begin
            job_valid  = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_update();
        drive();
        compute_exp();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((req_q.size() > 0 || m_pend || m_issued != m_popped) && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL idle_timeout @cyc %0d: got %0d cycles expected < %0d", cyc, n, budget);
        end
    endtask

    task automatic clear_logs();
        log_a.delete(); log_b.delete(); log_rdc.delete();
        log_out.delete(); log_acc.delete();
        first_psv = -1; n_psv_seen = 0;
    endtask

    function automatic logic [9:0] get_a(input int i);
        return (i < log_a.size()) ? log_a[i] : 10'bx;
    endfunction
    function automatic logic [9:0] get_b(input int i);
        return (i < log_b.size()) ? log_b[i] : 10'bx;
    endfunction
    function automatic logic [5:0] get_o(input int i);
        return (i < log_out.size()) ? log_out[i] : 6'bx;
    endfunction
    function automatic int get_acc(input int i);
        return (i < log_acc.size()) ? log_acc[i] : -1000;
    endfunction

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("job_ready", 64'(job_ready), 64'(e_ready));
            chk("rd_en",     64'(rd_en),     64'(e_rd));
            chk("busy",      64'(busy),      64'(e_busy));
            chk("ps_valid",  64'(ps_valid),  64'(e_psv));
            if (e_rd) begin
                chk("rd_addr_a", 64'(rd_addr_a), 64'(e_a));
                chk("rd_addr_b", 64'(rd_addr_b), 64'(e_b));
            end
            if (e_psv) begin
                chk("ps_data",  64'(ps_data),  64'(mq[0].data));
                chk("ps_first", 64'(ps_first), 64'(mq[0].first));
                chk("ps_last",  64'(ps_last),  64'(mq[0].last));
                chk("ps_tag",   64'(ps_tag),   64'(mq[0].tag));
            end
            if (rd_en) begin
                log_a.push_back(rd_addr_a);
                log_b.push_back(rd_addr_b);
                log_rdc.push_back(cyc);
            end
            if (ps_valid) begin
                n_psv_seen++;
                if (first_psv < 0) first_psv = cyc;
            end
            if (ps_valid && ps_ready) begin
                log_out.push_back({ps_tag, ps_first, ps_last});
                total_pops++;
            end
            if (job_valid && job_ready) log_acc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int total_exp;
        job_t j;

        model_reset();
        compute_exp();
        #1 rst_n = 1'b0;
        step();
        chk_en = 1;
        step();
        chk("rst_job_ready", 64'(job_ready), 64'd0);
        chk("rst_rd_en",     64'(rd_en),     64'd0);
        chk("rst_ps_valid",  64'(ps_valid),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_addr_a",    64'(rd_addr_a), 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 64'(job_ready), 64'd1);

        // Single 4-chunk job
        clear_logs();
        req_q.push_back('{10'h010, 10'h200, 10'd3, 4'd5});
        wait_idle(200);
        chk("t1_n_issue", 64'(log_rdc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr_a", 64'(get_a(i)), 64'(10'h010 + i));
            chk("t1_addr_b", 64'(get_b(i)), 64'(10'h200 + i));
            chk("t1_out", 64'(get_o(i)), 64'({4'd5, i == 0, i == 3}));
        end
        chk("t1_first_issue_lat", 64'(log_rdc[0] - get_acc(0)), 64'd1);
        chk("t1_first_psv_lat",   64'(first_psv - get_acc(0)), 64'd15);

        // Backpressure: 32-chunk job with ps_ready low for 40 cycles
        clear_logs();
        fix_ready = 0;
        req_q.push_back('{10'h100, 10'h180, 10'd31, 4'd7});
        repeat (40) step();
        chk("t2_stall_issue", 64'(log_rdc.size()), 64'd16);
        chk("t2_no_pop",      64'(log_out.size()), 64'd0);
        fix_ready = 1;
        wait_idle(300);
        chk("t2_n_out", 64'(log_out.size()), 64'd32);
        for (int i = 0; i < 32; i++) begin
            chk("t2_out", 64'(get_o(i)), 64'({4'd7, i == 0, i == 31}));
        end

        // Back-to-back jobs
        clear_logs();
        req_q.push_back('{10'h020, 10'h040, 10'd0, 4'd1});
        req_q.push_back('{10'h030, 10'h050, 10'd2, 4'd2});
        wait_idle(200);
        chk("t3_acc_gap",       64'(get_acc(1) - get_acc(0)), 64'd2);
        chk("t3_acc_after_iss", 64'(get_acc(1) - log_rdc[0]), 64'd1);
        chk("t3_out0", 64'(get_o(0)), 64'({4'd1, 1'b1, 1'b1}));
        chk("t3_out1", 64'(get_o(1)), 64'({4'd2, 1'b1, 1'b0}));
        chk("t3_out2", 64'(get_o(2)), 64'({4'd2, 1'b0, 1'b0}));
        chk("t3_out3", 64'(get_o(3)), 64'({4'd2, 1'b0, 1'b1}));

        // Address wrap
        clear_logs();
        req_q.push_back('{10'h3FE, 10'h001, 10'd3, 4'd3});
        wait_idle(200);
        chk("t4_wrap0", 64'(get_a(0)), 64'h3FE);
        chk("t4_wrap1", 64'(get_a(1)), 64'h3FF);
        chk("t4_wrap2", 64'(get_a(2)), 64'h000);
        chk("t4_wrap3", 64'(get_a(3)), 64'h001);

        // Reset with six chunks in flight
        clear_logs();
        req_q.push_back('{10'h050, 10'h060, 10'd20, 4'd9});
        n = 0;
        while (log_rdc.size() < 6 && n < 20) begin
            step();
            n++;
        end
        chk("t5_six_issued", 64'(log_rdc.size()), 64'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_rd_en",    64'(rd_en),     64'd0);
        chk("t5_rst_addr_a",   64'(rd_addr_a), 64'd0);
        chk("t5_rst_addr_b",   64'(rd_addr_b), 64'd0);
        chk("t5_rst_ps_valid", 64'(ps_valid),  64'd0);
        chk("t5_rst_busy",     64'(busy),      64'd0);
        chk("t5_rst_ready",    64'(job_ready), 64'd0);
        model_reset();
        compute_exp();
        repeat (2) step();
        rst_n = 1'b1;
        clear_logs();
        repeat (30) step();
        chk("t5_no_ps_after_rst", 64'(n_psv_seen), 64'd0);
        chk("t5_idle_busy",       64'(busy),       64'd0);

        // Randomised traffic: 1000 jobs with random gaps and backpressure
        clear_logs();
        total_pops = 0;
        total_exp = 0;
        rnd_ready = 1;
        rnd_job = 1;
        for (int i = 0; i < 1000; i++) begin
            j.a   = 10'($urandom);
            j.b   = 10'($urandom);
            j.len = 10'($urandom_range(0, 7));
            j.tag = 4'($urandom);
            total_exp += int'(j.len) + 1;
            req_q.push_back(j);
        end
        wait_idle(40000);
        rnd_ready = 0;
        fix_ready = 1;
        step();
        chk("t6_total_results", 64'(total_pops), 64'(total_exp));
        chk("t6_jobs_accepted", 64'(log_acc.size()), 64'd1000);
        chk("t6_busy_end", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
